dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  - Multi-cycle data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
//  - Accepts one word request from the CPU, waits a programmable number of cycles, then completes it with a one-cycle ready_o pulse.
//  - Drives busy_o so the hazard logic can freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
// PARAMETERS
//  DEPTH_WORDS  128  number of 32-bit words; power of two, >=2
//  LATENCY      2    wait cycles between request capture and response; 0..15
//  IDX_W        7    word-index width; must equal log2(DEPTH_WORDS)
// PORTS
//  clk_i    in   1   clock; all state changes on the rising edge
//  rst_i    in   1   asynchronous, active-high reset
//  req_i    in   1   request valid; held by the requester until it sees ready_o
//  we_i     in   1   1 = store, 0 = load; sampled with req_i
//  addr_i   in   32  byte address; word index = addr_i[IDX_W+1:2]
//  wdata_i  in   32  store data; sampled with req_i
//  rdata_o  out  32  load data, registered; valid while ready_o=1
//  ready_o  out  1   one-cycle completion pulse
//  busy_o   out  1   combinational stall to the pipeline
//  err_o    out  1   access fault, valid with ready_o; tied 0 unless DMEM_ERR_CHECK_EN
// BEHAVIOUR
//  - Reset (async, immediate):
//    - state=IDLE; rdata_o=0; ready_o=0; err_o=0; wait counter=0.
//    - All memory words cleared to 0.
//    - A request in flight is aborted and its store is discarded.
//  - FSM states: IDLE, WAIT, RESP.
//    - IDLE with req_i=1:
//      - latch we_i, addr_i and wdata_i.
//      - go to WAIT with counter=LATENCY-1; if LATENCY=0, go directly to RESP.
//    - IDLE with req_i=0: stay in IDLE.
//    - WAIT: decrement counter; when counter=0, go to RESP.
//    - RESP: ready_o=1 for exactly one cycle, then unconditionally IDLE.
//  - Latency: request sampled at edge k -> ready_o high during cycle k+LATENCY+1.
//  - Inputs are ignored in WAIT and RESP; only the latched copies are used.
//  - Handshake:
//    - The requester keeps req_i high through the RESP cycle.
//    - req_i seen in the IDLE cycle after RESP is a new request.
//    - Back-to-back throughput is therefore one access per LATENCY+2 cycles.
//  - Store: the array is written on the edge entering RESP; rdata_o = 0 for stores.
//  - Load: rdata_o is loaded on the edge entering RESP from the latched index.
//    - rdata_o holds its value until the next RESP; it is not cleared.
//  - Read-after-write: a load following a store to the same index returns the new data (the store has committed before the load is accepted).
//  - busy_o = (state==WAIT) | (state==IDLE & req_i) | (state==RESP & 0).
//    - busy_o is low in RESP so the pipeline advances on the completing edge.
//  - Address handling:
//    - addr_i[1:0] ignored (word access only).
//    - Bits above IDX_W+1 ignored, so addresses alias modulo DEPTH_WORDS*4.
//  - Counter width: 4 bits; LATENCY > 15 is illegal (elaboration $error).
// CONFIGURATION
//  DMEM_ERR_CHECK_EN defined:
//  - Fault = addr_i[1:0]!=0 or addr_i >= DEPTH_WORDS*4, evaluated at capture.
//  - On a fault, the store is suppressed, rdata_o=0 and err_o=1 with ready_o.
//  - Timing is unchanged: a fault still takes LATENCY+1 cycles.
//  - err_o is cleared on the edge leaving RESP.
//  DMEM_ERR_CHECK_EN not defined:
//  - err_o is constant 0.
//  - Address aliasing as described above; no fault logic is synthesized.
// TESTING
//  1. Reset: assert rst_i mid-cycle.
//     -> Outputs 0 immediately, without a clock edge.
//     -> A load from 0x0 then returns 0x00000000.
//  2. LATENCY=2: store 0xDEADBEEF to 0x10 at edge 0.
//     -> busy_o high in cycles 0..2; ready_o high in cycle 3 only.
//     -> A following load of 0x10 returns 0xDEADBEEF with ready_o 3 cycles after acceptance.
//  3. LATENCY=0: load request.
//     -> ready_o in the next cycle; busy_o high only in the IDLE cycle.
//     -> req_i held through RESP does not start a second access.
//  4. Aliasing (macro off, DEPTH_WORDS=128): store 0x1234 to 0x204, then load 0x004.
//     -> Load returns 0x1234; err_o stays 0.
//  5. DMEM_ERR_CHECK_EN on: store to 0x202, then store to 0x400.
//     -> err_o=1 with each ready_o.
//     -> A later load of 0x200 still returns its prior value.
//  6. Reset asserted during WAIT of a store to 0x8.
//     -> After release, a load of 0x8 returns 0 and no ready_o pulse occurred for the aborted store.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data memory responder (slave).
// Signal names follow the responder's view: _i driven by the CPU, _o by the memory.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ready_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ready_o, busy_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP pulse.
// Optional DMEM_ERR_CHECK_EN adds misaligned / out-of-range fault reporting on err_o.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2,
    parameter int IDX_W       = 7
) (
    input logic        clk_i,
    input logic        rst_i,
    dmem_responder_if.slave bus
);

    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
        $error("dmem_responder: LATENCY must be 0..15");
    end
    if (DEPTH_WORDS < 2 || (1 << IDX_W) != DEPTH_WORDS) begin : g_depth_chk
        $error("dmem_responder: DEPTH_WORDS must be 2**IDX_W and >= 2");
    end

    localparam logic [3:0] LAT_M1 = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]   in_idx;
    logic               in_fault;
    logic               start;
    logic               enter_resp;
    logic               acc_we;
    logic               acc_fault;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        acc_wdata;

    assign in_idx = bus.addr_i[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    logic fault_q;
    logic err_q;

    assign in_fault = (bus.addr_i[1:0] != 2'b00)
                    | (bus.addr_i >= 32'(DEPTH_WORDS * 4));
    assign bus.err_o = err_q;
`else
    logic fault_q;
    logic unused_addr;

    assign in_fault    = 1'b0;
    assign fault_q     = 1'b0;
    assign unused_addr = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};
    assign bus.err_o   = 1'b0;
`endif

    assign start = (state_q == IDLE) && bus.req_i;

    // Access takes place on the edge entering RESP; with zero latency that is the capture edge.
    assign enter_resp = (start && (LATENCY == 0))
                      || ((state_q == WAIT) && (cnt_q == 4'd0));

    // Select live inputs at capture, latched copies afterwards.
    always_comb begin
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_fault = fault_q;
        if (state_q == IDLE) begin
            acc_we    = bus.we_i;
            acc_idx   = in_idx;
            acc_wdata = bus.wdata_i;
            acc_fault = in_fault;
        end
    end

    assign bus.busy_o  = (state_q == WAIT) || start;
    assign bus.rdata_o = rdata_q;
    assign bus.ready_o = ready_q;

    // Storage array: cleared by reset, written when a non-faulting store completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enter_resp && acc_we && !acc_fault) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    // Fault flag latched at capture, reported with ready_o and cleared leaving RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                fault_q <= in_fault;
            end
            if (enter_resp) begin
                err_q <= acc_fault;
            end else if (state_q == RESP) begin
                err_q <= 1'b0;
            end
        end
    end
`endif

    // Request FSM with registered response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            if (enter_resp) begin
                rdata_q <= (acc_we || acc_fault) ? '0 : mem_q[acc_idx];
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        idx_q   <= in_idx;
                        wdata_q <= bus.wdata_i;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus random loads/stores
// checked against an array model of word memory.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        sb [$];
    logic [31:0] model [DEPTH];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .IDX_W      (7)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic is_fault(logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a % 4 != 0) || (a >= DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        sb.delete();
    endfunction

    // Monitor: every completion pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && bus.ready_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d want none", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("rdata", bus.rdata_o, x.d);
                chk("err", {31'b0, bus.err_o}, {31'b0, x.e});
                chk("ready_cycle", cyc, x.c);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        int   idx;
        int   n;
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = w;
        bus.addr_i  = a;
        bus.wdata_i = d;
        idx = int'((a / 4) % DEPTH);
        x.e = is_fault(a);
        x.d = (!w && !x.e) ? model[idx] : 32'h0;
        if (w && !x.e) model[idx] = d;
        x.c = cyc + LAT + 1;
        sb.push_back(x);
        #1 chk("busy_capture", {31'b0, bus.busy_o}, 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.ready_o) begin
                #1 chk("busy_resp", {31'b0, bus.busy_o}, 32'd0);
                break;
            end
            #1 chk("busy_wait", {31'b0, bus.busy_o}, 32'd1);
            if (n > LAT + 6) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got no ready after %0d cycles want %0d", n, LAT + 1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req_i = 1'b0;
            #1 chk("busy_idle", {31'b0, bus.busy_o}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd0);
        chk("rst_err", {31'b0, bus.err_o}, 32'd0);
        rst = 1'b0;
        idle(2);

        issue(1'b1, 32'h10, 32'hDEADBEEF);
        idle(1);
        issue(1'b0, 32'h10, 32'h0);

        @(negedge clk);
        bus.req_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdata", bus.rdata_o, 32'h0);
        chk("async_rst_ready", {31'b0, bus.ready_o}, 32'd0);
        chk("async_rst_busy", {31'b0, bus.busy_o}, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h0, 32'h0);
        issue(1'b0, 32'h10, 32'h0);
        idle(4);

        issue(1'b1, 32'h204, 32'h1234);
        issue(1'b0, 32'h004, 32'h0);
        idle(1);

        issue(1'b1, 32'h200, 32'h5A5A5A5A);
        issue(1'b1, 32'h202, 32'h11111111);
        issue(1'b1, 32'h400, 32'h22222222);
        issue(1'b0, 32'h200, 32'h0);
        idle(2);

        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 32'h8;
        bus.wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_ready", {31'b0, bus.ready_o}, 32'd0);
        bus.req_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(LAT + 3);
        issue(1'b0, 32'h8, 32'h0);
        idle(1);

        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            issue(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(LAT + 4);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
